debounce_event_arbiter: RTL and testbench



---
 rtl/debounce_event_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_debounce_event_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_event_arbiter.sv
// ---------------------------------------------------------------------------
// debounce_event_arbiter
//
// Purpose:
//   Four-channel push-button front end. Each raw button is debounced by a
//   small per-channel FSM that locks out further changes for HOLD cycles
//   after every accepted edge. Each accepted press (LOW -> LOCK_H) queues one
//   pending event for its channel. A round-robin arbiter drains the pending
//   events, one per accepted handshake, onto a single valid/ready port.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-high reset
//   b          in   4  raw button levels, already synchronous to clk
//   s          out  4  debounced button levels, registered
//   evt_valid  out  1  a press event is presented on evt_id
//   evt_id     out  2  channel index of the presented press
//   evt_ready  in   1  consumer accepts the event this cycle
//   ovf        out  1  sticky: a press was dropped because its channel was
//                      already pending
//
// Parameters:
//   HOLD  lock-out length in cycles after an accepted edge (1..15)
//   CW    lock-out counter width, must be able to hold HOLD-1
// ---------------------------------------------------------------------------
module debounce_event_arbiter #(
  parameter int HOLD = 3,
  parameter int CW   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  input  logic       evt_ready,
  output logic       ovf
);

  // Debounce FSM state encoding, shared by all four channels.
  localparam logic [1:0] ST_LOW    = 2'd0;
  localparam logic [1:0] ST_LOCK_H = 2'd1;
  localparam logic [1:0] ST_HIGH   = 2'd2;
  localparam logic [1:0] ST_LOCK_L = 2'd3;

  // Value loaded into the lock-out counter on an accepted edge. The lock
  // state is left at the edge where the counter reads zero, so loading
  // HOLD-1 gives a lock-out of exactly HOLD cycles.
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

  // Per-channel debounce state.
  logic [3:0][1:0]    state_q, state_d;
  logic [3:0][CW-1:0] cnt_q,   cnt_d;
  logic [3:0]         s_q,     s_d;
  logic [3:0]         press;

  // Arbiter and output-slot state.
  logic [3:0] pend_q,     pend_d;
  logic       evtValid_q, evtValid_d;
  logic [1:0] evtId_q,    evtId_d;
  logic [1:0] rrLast_q,   rrLast_d;
  logic       ovf_q,      ovf_d;

  // Arbiter helpers.
  logic       slotFree;
  logic       found;
  logic [1:0] winner;
  logic [1:0] cand;
  logic [3:0] grantVec;

  // Debounce FSMs: every channel runs the same four-state machine. The
  // debounced level is registered alongside the state and changes on the
  // very edge that accepts a button change, so s adds no extra latency.
  // Only the LOW -> LOCK_H transition reports a press; releases never do.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    press   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      case (state_q[i])
        ST_LOW: begin
          s_d[i] = 1'b0;
          if (b[i]) begin
            state_d[i] = ST_LOCK_H;
            cnt_d[i]   = HOLD_M1;
            s_d[i]     = 1'b1;
            press[i]   = 1'b1;
          end
        end
        ST_LOCK_H: begin
          s_d[i] = 1'b1;
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_HIGH;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        ST_HIGH: begin
          s_d[i] = 1'b1;
          if (!b[i]) begin
            state_d[i] = ST_LOCK_L;
            cnt_d[i]   = HOLD_M1;
            s_d[i]     = 1'b0;
          end
        end
        ST_LOCK_L: begin
          s_d[i] = 1'b0;
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_LOW;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
          s_d[i]     = 1'b0;
        end
      endcase
    end
  end

  // Round-robin search: look at rrLast+1, rrLast+2, ... wrapping modulo 4,
  // and take the first channel with a pending press. The last candidate
  // (k = 4) wraps back onto rrLast itself so it is considered last.
  always_comb begin
    found  = 1'b0;
    winner = rrLast_q;
    cand   = rrLast_q;
    for (int k = 1; k <= 4; k++) begin
      cand = rrLast_q + 2'(k);
      if (!found && pend_q[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Output slot and pending bookkeeping. The slot can take a new event when
  // it is empty or its current event is being accepted this cycle; a
  // stalled slot holds valid and id stable. A new press on the channel that
  // is granted this cycle re-sets its pend bit (set wins over clear), and
  // that case is not an overflow because the earlier press has just left.
  always_comb begin
    slotFree   = !evtValid_q || evt_ready;
    grantVec   = (slotFree && found) ? (4'b0001 << winner) : 4'b0000;
    pend_d     = (pend_q & ~grantVec) | press;
    ovf_d      = ovf_q | (|(press & pend_q & ~grantVec));
    evtValid_d = evtValid_q;
    evtId_d    = evtId_q;
    rrLast_d   = rrLast_q;
    if (slotFree) begin
      if (found) begin
        evtValid_d = 1'b1;
        evtId_d    = winner;
        rrLast_d   = winner;
      end else begin
        evtValid_d = 1'b0;
      end
    end
  end

  // State registers. rrLast resets to 3 so channel 0 holds first priority
  // after reset; reset also discards any in-flight or pending events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= {4{ST_LOW}};
      cnt_q      <= '0;
      s_q        <= 4'b0000;
      pend_q     <= 4'b0000;
      evtValid_q <= 1'b0;
      evtId_q    <= 2'd0;
      rrLast_q   <= 2'd3;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      pend_q     <= pend_d;
      evtValid_q <= evtValid_d;
      evtId_q    <= evtId_d;
      rrLast_q   <= rrLast_d;
      ovf_q      <= ovf_d;
    end
  end

  assign s         = s_q;
  assign evt_valid = evtValid_q;
  assign evt_id    = evtId_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_debounce_event_arbiter
//
// Purpose:
//   Self-checking bench for debounce_event_arbiter (HOLD = 3). Cycle-level
//   behaviour is driven from a table of {inputs, expected outputs} records;
//   bounce, release and asynchronous-reset corners use hand-written
//   sequences with sub-cycle timing.
//
// Ports: none (top-level bench). Clock period 60 ns, first rise at 30 ns.
// ---------------------------------------------------------------------------
module tb_debounce_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] b;
  logic [3:0] s;
  logic       evtValid;
  logic [1:0] evtId;
  logic       evtReady;
  logic       ovf;

  int compared;
  int mismatched;

  typedef struct {
    bit         rst;
    logic [3:0] b;
    logic       rdy;
    logic [3:0] s;
    logic       v;
    logic [1:0] id;
    logic       o;
  } vec_t;

  vec_t vecs[48];
  int   nVec;

  debounce_event_arbiter #(.HOLD(3), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .b         (b),
    .s         (s),
    .evt_valid (evtValid),
    .evt_id    (evtId),
    .evt_ready (evtReady),
    .ovf       (ovf)
  );

  // Free-running clock: rising edges at 30, 90, 150, ... ns.
  initial begin
    clk = 1'b0;
    forever #30 clk = ~clk;
  end

  // One comparison; a mismatch prints a single FAIL line.
  task automatic checkVal(input string name, input int idx,
                          input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic addVec(input bit rst, input logic [3:0] bi, input logic rdy,
                        input logic [3:0] se, input logic ve,
                        input logic [1:0] ide, input logic oe);
    vecs[nVec] = '{rst: rst, b: bi, rdy: rdy, s: se, v: ve, id: ide, o: oe};
    nVec++;
  endtask

  // Outputs are compared 1 ns after the edge that sampled the vector; the
  // id is only meaningful while an event is presented.
  task automatic checkOutput(input int idx);
    checkVal("s",         idx, s,                vecs[idx].s);
    checkVal("evt_valid", idx, {3'b000, evtValid}, {3'b000, vecs[idx].v});
    checkVal("ovf",       idx, {3'b000, ovf},    {3'b000, vecs[idx].o});
    if (vecs[idx].v)
      checkVal("evt_id",  idx, {2'b00, evtId},   {2'b00, vecs[idx].id});
  endtask

  // Drive one vector on the falling edge, optionally after a short reset
  // pulse that lies entirely between two rising edges.
  task automatic applyStimulus(input int idx);
    @(negedge clk);
    if (vecs[idx].rst) begin
      reset = 1'b1;
      b     = 4'b0000;
      #5;
      reset = 1'b0;
    end
    b        = vecs[idx].b;
    evtReady = vecs[idx].rdy;
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(i);
  endtask

  // Bouncy press on b[0], rising 5 ns before an edge: s[0] must rise on
  // that edge and never drop, and exactly one event (id 0) must appear,
  // presented after the second edge.
  task automatic bouncePress();
    int evtCount;
    evtCount = 0;
    @(negedge clk);
    #25;
    b[0] = 1'b1;
    fork
      begin
        #10 b[0] = 1'b0;
        #15 b[0] = 1'b1;
        #20 b[0] = 1'b0;
        #15 b[0] = 1'b1;
        #20 b[0] = 1'b0;
        #20 b[0] = 1'b1;
      end
      begin
        for (int k = 1; k <= 8; k++) begin
          @(posedge clk);
          #1;
          checkVal("bounce_s", 100 + k, s, 4'b0001);
          checkVal("bounce_valid", 100 + k, {3'b000, evtValid}, (k == 2) ? 4'd1 : 4'd0);
          if (k == 2) checkVal("bounce_id", 100 + k, {2'b00, evtId}, 4'd0);
          if (evtValid && evtReady) evtCount++;
        end
      end
    join
    checkVal("bounce_event_count", 109, 4'(evtCount), 4'd1);
  endtask

  // Bouncy release of b[0], shorter than HOLD cycles: s[0] drops on the
  // first edge that sees 0 and stays low; a release raises no event.
  task automatic bounceRelease();
    @(negedge clk);
    #25;
    b[0] = 1'b0;
    fork
      begin
        #10 b[0] = 1'b1;
        #20 b[0] = 1'b0;
        #20 b[0] = 1'b1;
        #20 b[0] = 1'b0;
      end
      begin
        for (int k = 1; k <= 6; k++) begin
          @(posedge clk);
          #1;
          checkVal("release_s", 200 + k, s, 4'b0000);
          checkVal("release_valid", 200 + k, {3'b000, evtValid}, 4'd0);
        end
      end
    join
  endtask

  // Reset asserted in the middle of a cycle clears everything at once and
  // keeps it cleared across an edge. Reset is left asserted; the next
  // table vector releases it.
  task automatic midReset();
    #15;
    reset = 1'b1;
    b     = 4'b0000;
    #1;
    checkVal("midrst_s",     300, s,                  4'b0000);
    checkVal("midrst_valid", 300, {3'b000, evtValid}, 4'd0);
    checkVal("midrst_ovf",   300, {3'b000, ovf},      4'd0);
    checkVal("midrst_id",    300, {2'b00, evtId},     4'd0);
    @(posedge clk);
    #1;
    checkVal("midrst_hold_valid", 301, {3'b000, evtValid}, 4'd0);
    checkVal("midrst_hold_s",     301, s,                  4'b0000);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    nVec       = 0;
    reset      = 1'b1;
    b          = 4'b0000;
    evtReady   = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) addVec(0, 4'h0, 1, 4'h0, 0, 0, 0);
    // All four pressed at once, drained 0,1,2,3 then idle; then release.
    addVec(1, 4'hF, 1, 4'hF, 0, 0, 0);
    addVec(0, 4'hF, 1, 4'hF, 1, 0, 0);
    addVec(0, 4'hF, 1, 4'hF, 1, 1, 0);
    addVec(0, 4'hF, 1, 4'hF, 1, 2, 0);
    addVec(0, 4'hF, 1, 4'hF, 1, 3, 0);
    addVec(0, 4'hF, 1, 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) addVec(0, 4'h0, 1, 4'h0, 0, 0, 0);
    // Stalled consumer: press 2 then 1; 2 held, then 2 and 1 drain.
    addVec(0, 4'h4, 0, 4'h4, 0, 0, 0);
    addVec(0, 4'h6, 0, 4'h6, 1, 2, 0);
    addVec(0, 4'h6, 0, 4'h6, 1, 2, 0);
    addVec(0, 4'h6, 0, 4'h6, 1, 2, 0);
    addVec(0, 4'h6, 1, 4'h6, 1, 1, 0);
    addVec(0, 4'h6, 1, 4'h6, 0, 0, 0);
    for (int i = 0; i < 4; i++) addVec(0, 4'h0, 1, 4'h0, 0, 0, 0);
    // Overflow: slot held by ch0, ch3 pending, ch3 released and re-pressed.
    addVec(0, 4'h1, 0, 4'h1, 0, 0, 0);
    addVec(0, 4'h9, 0, 4'h9, 1, 0, 0);
    addVec(0, 4'h9, 0, 4'h9, 1, 0, 0);
    addVec(0, 4'h9, 0, 4'h9, 1, 0, 0);
    addVec(0, 4'h1, 0, 4'h9, 1, 0, 0);
    for (int i = 0; i < 4; i++) addVec(0, 4'h1, 0, 4'h1, 1, 0, 0);
    addVec(0, 4'h9, 0, 4'h9, 1, 0, 1);
    addVec(0, 4'h9, 0, 4'h9, 1, 0, 1);
    // Same-cycle grant and re-press of ch0: pend stays set, no overflow.
    addVec(1, 4'h2, 0, 4'h2, 0, 0, 0);
    addVec(0, 4'h3, 0, 4'h3, 1, 1, 0);
    addVec(0, 4'h3, 0, 4'h3, 1, 1, 0);
    addVec(0, 4'h2, 0, 4'h3, 1, 1, 0);
    addVec(0, 4'h2, 0, 4'h3, 1, 1, 0);
    for (int i = 0; i < 4; i++) addVec(0, 4'h2, 0, 4'h2, 1, 1, 0);
    addVec(0, 4'h3, 1, 4'h3, 1, 0, 0);
    addVec(0, 4'h3, 1, 4'h3, 1, 0, 0);
    addVec(0, 4'h3, 1, 4'h3, 0, 0, 0);

    #10;
    checkVal("reset_s",     0, s,                  4'b0000);
    checkVal("reset_valid", 0, {3'b000, evtValid}, 4'd0);
    checkVal("reset_id",    0, {2'b00, evtId},     4'd0);
    checkVal("reset_ovf",   0, {3'b000, ovf},      4'd0);
    #10;
    reset = 1'b0;

    runVectors(0, 4);
    bouncePress();
    bounceRelease();
    runVectors(5, 35);
    midReset();
    runVectors(36, nVec - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
